pipeline_stall_ctrl: RTL

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall FSM; in: id_rs1/rs2, id_ex_rd/mem_read/is_div, ex_branch_taken, div_done; out: write enables, flushes, bubble, div_start, div_timeout, stall/flush counters
module pipeline_stall_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_is_div,
  input  logic             ex_branch_taken,
  input  logic             div_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             div_start,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int TW = DIV_TIMEOUT > 1 ? $clog2(DIV_TIMEOUT) : 1;
  typedef enum logic [1:0] {RUN = 2'd0, DIV_BUSY = 2'd1, HALT = 2'd2} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic load_use, tmo, run, busy_wait, halt, br, dv, lu, freeze;
  assign load_use = id_ex_mem_read && id_ex_rd != 5'd0 && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
  assign tmo = tcnt == TW'(DIV_TIMEOUT - 1);
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nx;
  always_comb begin
    state_nx = state;
    if (state == RUN && id_ex_is_div && !ex_branch_taken) state_nx = DIV_BUSY;
    else if (state == DIV_BUSY) state_nx = div_done ? RUN : tmo ? HALT : DIV_BUSY;
  end
  always_comb begin
    run = !rst && state == RUN;
    busy_wait = !rst && state == DIV_BUSY && !div_done;
    halt = !rst && state == HALT;
    br = run && ex_branch_taken;
    dv = run && !ex_branch_taken && id_ex_is_div;
    lu = run && !ex_branch_taken && !id_ex_is_div && load_use;
    freeze = dv || busy_wait || halt;
    pc_write = !(freeze || lu);
    if_id_write = !(freeze || lu);
    id_ex_write = !freeze;
    if_id_flush = br;
    id_ex_flush = br || lu;
    ex_mem_bubble = freeze;
    div_start = dv;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      div_timeout <= 1'b0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      tcnt <= dv ? '0 : busy_wait ? tcnt + TW'(1) : tcnt;
      div_timeout <= div_timeout || state_nx == HALT;
      stall_cycles <= stall_cycles + CNT_W'(!pc_write);
      flush_count <= flush_count + CNT_W'(if_id_flush);
    end
  end
endmodule
